// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared state encoding, trap sources and mcause constants for trap_ctrl
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_VECTOR  = 3'd2,
    ST_HANDLER = 3'd3,
    ST_RETURN  = 3'd4
  } trap_state_t;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_STACK = 2'd1,
    SRC_ECALL = 2'd2,
    SRC_UART  = 2'd3
  } trap_src_t;

  localparam logic [31:0] CAUSE_ECALL = 32'h0000_000B;
  localparam logic [31:0] CAUSE_STACK = 32'h0000_0018;
  localparam logic [31:0] CAUSE_UART  = 32'h8000_000B;

  // mcause value for a winning source; SRC_NONE maps to zero so an idle encoder drives a clean bus.
  function automatic logic [31:0] src_cause(input trap_src_t src);
    case (src)
      SRC_STACK: src_cause = CAUSE_STACK;
      SRC_ECALL: src_cause = CAUSE_ECALL;
      SRC_UART:  src_cause = CAUSE_UART;
      default:   src_cause = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/trap_prio.sv
// rtl/trap_prio.sv - fixed-priority trap source encoder (stack > ecall > uart)
module trap_prio
  import trap_pkg::*;
(
  input  logic        stk_req,
  input  logic        ecall_req,
  input  logic        irq_req,
  output logic        valid,
  output logic        stk_sel,
  output logic [31:0] cause
);

  trap_src_t src;

  // Pick the single highest-priority requester; lower requests are simply dropped this cycle.
  always_comb begin
    src = SRC_NONE;
    if (stk_req) begin
      src = SRC_STACK;
    end else if (ecall_req) begin
      src = SRC_ECALL;
    end else if (irq_req) begin
      src = SRC_UART;
    end
  end

  assign valid   = (src != SRC_NONE);
  assign stk_sel = (src == SRC_STACK);
  assign cause   = src_cause(src);

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap sequencer: prioritise, flush, vector, handler and mret return
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned MTVEC_ALIGN = 2
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        ecall,
  input  logic        uart_irq,
  input  logic        stack_mismatch,
  input  logic        mret,
  input  logic        mstatus_mie,
  input  logic        mie_meie,
  input  logic [31:0] pres_addr,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        trigger_trap,
  output logic [31:0] trap_cause,
  output logic [31:0] trap_pc,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_addr,
  output logic        trapping
);

  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << MTVEC_ALIGN) - 32'd1);

  trap_state_t state;
  logic        stk_prev;
  logic        stk_pend;
  logic        stk_rise;
  logic        stk_req;
  logic        irq_ok;
  logic        prio_valid;
  logic        prio_stk;
  logic [31:0] prio_cause;
  logic        retrap;
  logic        stk_clear;

  // A same-cycle rising edge counts as pending so it competes with a simultaneous ecall.
  assign stk_rise  = stack_mismatch & ~stk_prev;
  assign stk_req   = stk_pend | stk_rise;
  assign irq_ok    = uart_irq & mstatus_mie & mie_meie;
  assign retrap    = (state == ST_HANDLER) && mret && stk_req;
  assign stk_clear = ((state == ST_IDLE) && prio_stk) || retrap;

  trap_prio u_prio (
    .stk_req   (stk_req),
    .ecall_req (ecall & ~trapping),
    .irq_req   (irq_ok),
    .valid     (prio_valid),
    .stk_sel   (prio_stk),
    .cause     (prio_cause)
  );

  // Sequencer with registered outputs: every output is computed for the state being entered.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state         <= ST_IDLE;
      stk_prev      <= stack_mismatch;  // a mismatch rising under reset is absorbed, not pended
      stk_pend      <= 1'b0;
      trigger_trap  <= 1'b0;
      trap_cause    <= 32'h0;
      trap_pc       <= 32'h0;
      flush         <= 1'b0;
      redirect      <= 1'b0;
      redirect_addr <= 32'h0;
      trapping      <= 1'b0;
    end else begin
      stk_prev     <= stack_mismatch;
      stk_pend     <= stk_req & ~stk_clear;
      trigger_trap <= 1'b0;
      flush        <= 1'b0;
      redirect     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (prio_valid) begin
            state      <= ST_FLUSH;
            flush      <= 1'b1;
            trap_cause <= prio_cause;
            trap_pc    <= pres_addr;
          end
        end
        ST_FLUSH: begin
          state         <= ST_VECTOR;
          trigger_trap  <= 1'b1;
          redirect      <= 1'b1;
          redirect_addr <= mtvec & ALIGN_MASK;
        end
        ST_VECTOR: begin
          state    <= ST_HANDLER;
          trapping <= 1'b1;
        end
        ST_HANDLER: begin
          if (mret) begin
            flush <= 1'b1;
            if (stk_req) begin
              // Mismatch seen during the handler: chain straight into a fresh stack trap at mepc.
              state      <= ST_FLUSH;
              trap_cause <= CAUSE_STACK;
              trap_pc    <= mepc;
              trapping   <= 1'b0;
            end else begin
              state         <= ST_RETURN;
              redirect      <= 1'b1;
              redirect_addr <= mepc;
            end
          end
        end
        ST_RETURN: begin
          state    <= ST_IDLE;
          trapping <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          trapping <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - scoreboard bench for trap_ctrl
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        Rst;
  logic        ecall;
  logic        uart_irq;
  logic        stack_mismatch;
  logic        mret;
  logic        mstatus_mie;
  logic        mie_meie;
  logic [31:0] pres_addr;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        trigger_trap;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        trapping;

  typedef struct {
    logic [31:0] cause;
    logic [31:0] pc;
    logic [31:0] vec;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  trap_ctrl #(.MTVEC_ALIGN(2)) dut (
    .clk            (clk),
    .Rst            (Rst),
    .ecall          (ecall),
    .uart_irq       (uart_irq),
    .stack_mismatch (stack_mismatch),
    .mret           (mret),
    .mstatus_mie    (mstatus_mie),
    .mie_meie       (mie_meie),
    .pres_addr      (pres_addr),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .trigger_trap   (trigger_trap),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .flush          (flush),
    .redirect       (redirect),
    .redirect_addr  (redirect_addr),
    .trapping       (trapping)
  );

  always #5 clk = ~clk;

  // Scoreboard: every trigger_trap pulse must match the oldest expected trap.
  always @(negedge clk) begin
    if (trigger_trap === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_trap: got cause %h pc %h, want no trap", trap_cause, trap_pc);
      end else begin
        mon_e = sb.pop_front();
        if ({trap_cause, trap_pc, redirect_addr, redirect} !== {mon_e.cause, mon_e.pc, mon_e.vec, 1'b1}) begin
          errors++;
          $display("FAIL trap_fields: got cause %h pc %h vec %h redir %b, want cause %h pc %h vec %h redir 1",
                   trap_cause, trap_pc, redirect_addr, redirect, mon_e.cause, mon_e.pc, mon_e.vec);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_flush(input int budget, input string name);
    int n = 0;
    while (flush !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (flush !== 1'b1) begin
      errors++;
      $display("FAIL %s_flush_timeout: got flush %b, want 1 within %0d cycles", name, flush, budget);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_trap_timeout: got %0d pending traps, want 0", name, sb.size());
    end
  endtask

  task automatic do_return(input logic [31:0] addr);
    tick;
    mepc = addr;
    mret = 1'b1;
    tick;
    mret = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    Rst = 1'b1; ecall = 0; uart_irq = 0; stack_mismatch = 0; mret = 0;
    mstatus_mie = 0; mie_meie = 0; pres_addr = 0; mtvec = 0; mepc = 0;
    repeat (3) tick;
    @(negedge clk);
    checks++;
    if ({trigger_trap, flush, redirect, trapping} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got trig/flush/redir/trapping %b%b%b%b, want 0000", trigger_trap, flush, redirect, trapping);
    end
    checks++;
    if ({trap_cause, trap_pc, redirect_addr} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data: got cause %h pc %h raddr %h, want 0", trap_cause, trap_pc, redirect_addr);
    end
    tick;
    Rst = 1'b0;
  endtask

  task automatic test_ecall;
    mtvec = 32'h0000_0101;
    pres_addr = 32'h0000_0040;
    tick;
    ecall = 1'b1;
    sb.push_back('{32'h0000_000B, 32'h0000_0040, 32'h0000_0100});
    @(negedge clk);
    checks++;
    if (flush !== 1'b0) begin
      errors++;
      $display("FAIL ecall_n0: got flush %b, want 0", flush);
    end
    @(negedge clk);
    checks++;
    if ({flush, trigger_trap} !== 2'b10) begin
      errors++;
      $display("FAIL ecall_n1: got flush %b trig %b, want 1 0", flush, trigger_trap);
    end
    tick;
    ecall = 1'b0;
    @(negedge clk);
    checks++;
    if ({trigger_trap, redirect, flush} !== 3'b110) begin
      errors++;
      $display("FAIL ecall_n2: got trig %b redir %b flush %b, want 1 1 0", trigger_trap, redirect, flush);
    end
    @(negedge clk);
    checks++;
    if ({trapping, trigger_trap} !== 2'b10) begin
      errors++;
      $display("FAIL ecall_n3: got trapping %b trig %b, want 1 0", trapping, trigger_trap);
    end
    tick;
    mepc = 32'h0000_0044;
    mret = 1'b1;
    tick;
    mret = 1'b0;
    @(negedge clk);
    checks++;
    if ({redirect, flush, trapping, redirect_addr} !== {3'b111, 32'h0000_0044}) begin
      errors++;
      $display("FAIL mret_m1: got redir %b flush %b trapping %b raddr %h, want 1 1 1 00000044",
               redirect, flush, trapping, redirect_addr);
    end
    @(negedge clk);
    checks++;
    if ({redirect, flush, trapping} !== 3'b000) begin
      errors++;
      $display("FAIL mret_m2: got redir %b flush %b trapping %b, want 0 0 0", redirect, flush, trapping);
    end
    checks++;
    if ({trap_cause, trap_pc} !== {32'h0000_000B, 32'h0000_0040}) begin
      errors++;
      $display("FAIL cause_hold: got cause %h pc %h, want 0000000b 00000040", trap_cause, trap_pc);
    end
  endtask

  task automatic test_irq_gate;
    int bad = 0;
    pres_addr = 32'h0000_0060;
    mtvec = 32'h0000_1003;
    mstatus_mie = 1'b0;
    mie_meie = 1'b1;
    tick;
    uart_irq = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (flush !== 1'b0 || trigger_trap !== 1'b0 || trapping !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL irq_masked: got %0d active cycles, want 0", bad);
    end
    sb.push_back('{32'h8000_000B, 32'h0000_0060, 32'h0000_1000});
    tick;
    mstatus_mie = 1'b1;
    wait_flush(5, "irq");
    tick;
    uart_irq = 1'b0;
    wait_drain(5, "irq");
    @(negedge clk);
    checks++;
    if (trapping !== 1'b1) begin
      errors++;
      $display("FAIL irq_handler: got trapping %b, want 1", trapping);
    end
    do_return(32'h0000_0064);
  endtask

  task automatic test_back_to_back;
    mtvec = 32'h0000_0200;
    pres_addr = 32'h0000_0080;
    tick;
    stack_mismatch = 1'b1;
    ecall = 1'b1;
    uart_irq = 1'b1;
    sb.push_back('{32'h0000_0018, 32'h0000_0080, 32'h0000_0200});
    wait_flush(4, "simul");
    tick;
    stack_mismatch = 1'b0;
    uart_irq = 1'b0;
    wait_drain(4, "simul");
    @(negedge clk);
    checks++;
    if (trapping !== 1'b1) begin
      errors++;
      $display("FAIL simul_handler: got trapping %b, want 1", trapping);
    end
    sb.push_back('{32'h0000_000B, 32'h0000_0080, 32'h0000_0200});
    do_return(32'h0000_0084);
    wait_flush(4, "second_ecall");
    tick;
    ecall = 1'b0;
    wait_drain(4, "second_ecall");
    @(negedge clk);
    do_return(32'h0000_0084);
    checks++;
    if (trapping !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: got trapping %b, want 0", trapping);
    end
  endtask

  task automatic test_stack_in_handler;
    mtvec = 32'h0000_0300;
    pres_addr = 32'h0000_0090;
    tick;
    ecall = 1'b1;
    sb.push_back('{32'h0000_000B, 32'h0000_0090, 32'h0000_0300});
    wait_flush(4, "stk_pre");
    tick;
    ecall = 1'b0;
    wait_drain(4, "stk_pre");
    @(negedge clk);
    tick;
    stack_mismatch = 1'b1;
    tick;
    stack_mismatch = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({trapping, flush} !== 2'b10) begin
      errors++;
      $display("FAIL stk_held: got trapping %b flush %b, want 1 0", trapping, flush);
    end
    sb.push_back('{32'h0000_0018, 32'h0000_0200, 32'h0000_0300});
    tick;
    mepc = 32'h0000_0200;
    mret = 1'b1;
    tick;
    mret = 1'b0;
    @(negedge clk);
    checks++;
    if ({flush, redirect} !== 2'b10) begin
      errors++;
      $display("FAIL stk_retrap_flush: got flush %b redir %b, want 1 0", flush, redirect);
    end
    wait_drain(4, "stk_retrap");
    @(negedge clk);
    checks++;
    if (trapping !== 1'b1) begin
      errors++;
      $display("FAIL stk_retrap_handler: got trapping %b, want 1", trapping);
    end
    do_return(32'h0000_0204);
    checks++;
    if (trapping !== 1'b0) begin
      errors++;
      $display("FAIL stk_idle: got trapping %b, want 0", trapping);
    end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    pres_addr = 32'h0000_00A0;
    mtvec = 32'h0000_0400;
    tick;
    ecall = 1'b1;
    tick;
    Rst = 1'b1;
    ecall = 1'b0;
    @(negedge clk);
    checks++;
    if (flush !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_flush: got flush %b, want 1", flush);
    end
    tick;
    Rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({trigger_trap, flush, redirect, trapping, trap_cause, trap_pc, redirect_addr} !== 100'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got trig %b flush %b redir %b trapping %b cause %h pc %h raddr %h, want all 0",
               trigger_trap, flush, redirect, trapping, trap_cause, trap_pc, redirect_addr);
    end
    tick;
    Rst = 1'b1;
    stack_mismatch = 1'b1;
    tick;
    Rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (flush !== 1'b0 || trapping !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_stk_discard: got %0d active cycles, want 0", bad);
    end
    tick;
    stack_mismatch = 1'b0;
    pres_addr = 32'h0000_00B0;
    sb.push_back('{32'h0000_000B, 32'h0000_00B0, 32'h0000_0400});
    tick;
    ecall = 1'b1;
    wait_flush(4, "post_rst");
    tick;
    ecall = 1'b0;
    wait_drain(4, "post_rst");
    @(negedge clk);
    do_return(32'h0000_00B4);
  endtask

  task automatic test_mret_idle;
    mepc = 32'h0000_0300;
    tick;
    mret = 1'b1;
    tick;
    mret = 1'b0;
    @(negedge clk);
    checks++;
    if ({redirect, flush, trapping} !== 3'b000) begin
      errors++;
      $display("FAIL mret_idle: got redir %b flush %b trapping %b, want 0 0 0", redirect, flush, trapping);
    end
  endtask

  initial begin
    test_reset;
    test_ecall;
    test_irq_gate;
    test_back_to_back;
    test_stack_in_handler;
    test_reset_mid;
    test_mret_idle;
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover_traps: got %0d expected traps never seen, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
